// File: rtl/sens_event_monitor.sv
// sens_event_monitor: per-channel change capture with coalescing, round-robin arbitration into an event FIFO.
// Latency: a change sampled at edge k is pending at k, pushed at k+1 at the earliest, and visible on evt_* after k+1.
// Backpressure: a full FIFO with no pop holds the pending flags, so events merge but are never dropped.
module sens_event_monitor #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  input  logic [NUM_CH-1:0]            ch_mask,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [CH_W-1:0]              evt_ch,
  output logic [DATA_W-1:0]            evt_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [15:0]                  coalesce_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INC_W = CH_W + 1;

  // Change-capture state
  logic [DATA_W-1:0] r_prev [NUM_CH];
  logic              r_primed;
  logic [NUM_CH-1:0] r_pending;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [15:0]       r_coal;

  // Event FIFO state
  logic [CH_W-1:0]   r_mem_ch  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_dat [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [NUM_CH-1:0] w_chg;
  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_pend_nxt;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_idx;
  logic              w_pop;
  logic              w_push;
  logic [INC_W-1:0]  w_coal_inc;
  logic [16:0]       w_coal_sum;

  // Masked change detection against the previous sample; suppressed until primed
  always_comb begin
    w_chg = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_chg[c] = r_primed & ch_mask[c] & (ch_data[c*DATA_W +: DATA_W] != r_prev[c]);
    end
    // A channel being masked out this edge is also being cleared, so it must not be granted
    w_req = r_pending & ch_mask;
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (!w_gnt_vld && w_req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  // Push permission: room in the FIFO, or a slot freed by a same-edge pop
  always_comb begin
    w_pop  = evt_valid & evt_ready;
    w_push = w_gnt_vld & ((r_count < CNT_W'(FIFO_DEPTH)) | w_pop);
  end

  // Pending-flag next state and coalesce increment; a new change beats a same-edge push clear
  always_comb begin
    w_pend_nxt = r_pending;
    w_coal_inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!ch_mask[c]) begin
        w_pend_nxt[c] = 1'b0;
      end else if (w_chg[c]) begin
        w_pend_nxt[c] = 1'b1;
        if (r_pending[c] && !(w_push && (w_gnt_idx == CH_W'(c)))) begin
          w_coal_inc = w_coal_inc + INC_W'(1);
        end
      end else if (w_push && (w_gnt_idx == CH_W'(c))) begin
        w_pend_nxt[c] = 1'b0;
      end
    end
    w_coal_sum = {1'b0, r_coal} + 17'(w_coal_inc);
  end

  // Capture state: priming, previous samples, pending flags, arbiter pointer, saturating merge count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_prev[c] <= '0;
      end
      r_primed  <= 1'b0;
      r_pending <= '0;
      r_rr_ptr  <= CH_W'(NUM_CH - 1);
      r_coal    <= '0;
    end else begin
      r_primed <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        r_prev[c] <= ch_data[c*DATA_W +: DATA_W];
      end
      r_pending <= w_pend_nxt;
      if (w_push) begin
        r_rr_ptr <= w_gnt_idx;
      end
      r_coal <= w_coal_sum[16] ? 16'hFFFF : w_coal_sum[15:0];
    end
  end

  // FIFO storage; entry carries the channel index and its value as sampled on the previous edge
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ch[r_wr_ptr]  <= w_gnt_idx;
      r_mem_dat[r_wr_ptr] <= r_prev[w_gnt_idx];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head of FIFO drives the event port; forced to zero while empty so reset clears it immediately
  always_comb begin
    evt_valid    = (r_count != '0);
    evt_ch       = evt_valid ? r_mem_ch[r_rd_ptr]  : '0;
    evt_data     = evt_valid ? r_mem_dat[r_rd_ptr] : '0;
    fifo_count   = r_count;
    coalesce_cnt = r_coal;
  end

endmodule

// File: tb/tb_sens_event_monitor.sv
// Testbench for sens_event_monitor: vector table for detection/arbitration/masking,
// hand sequences for FIFO fill, coalescing, wrap-around drain and async reset.
// Popped events are checked against an expected-event queue.
module tb_sens_event_monitor;

  logic        clk;
  logic        rst_n;
  logic [15:0] ch_data;
  logic [3:0]  ch_mask;
  logic        evt_valid;
  logic        evt_ready;
  logic [1:0]  evt_ch;
  logic [3:0]  evt_data;
  logic [3:0]  fifo_count;
  logic [15:0] coalesce_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [5:0] sb [$];

  typedef struct {
    logic [15:0] dat;
    logic [3:0]  msk;
    logic        rdy;
    logic        vld;
    int          cnt;
    logic [1:0]  ch;
    logic [3:0]  d;
    int          coal;
  } vec_t;

  vec_t tbl [20];

  sens_event_monitor #(
    .NUM_CH(4), .DATA_W(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_data(ch_data),
    .ch_mask(ch_mask),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch(evt_ch),
    .evt_data(evt_data),
    .fifo_count(fifo_count),
    .coalesce_cnt(coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [15:0] d, input logic r);
    ch_data   = d;
    evt_ready = r;
    tick();
  endtask

  task automatic check_head(input string nm, input int cnt, input logic [1:0] ch, input logic [3:0] d);
    check({nm, "_cnt"}, fifo_count, cnt);
    check({nm, "_vld"}, evt_valid, 1'b1);
    check({nm, "_head"}, {evt_ch, evt_data}, {ch, d});
  endtask

  // Scoreboard: every accepted event must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got ch=%0d data=%0h, no event expected", evt_ch, evt_data);
      end else begin
        check("sb_evt", {evt_ch, evt_data}, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    //          data      mask  rdy   vld  cnt ch    d     coal
    tbl[0]  = '{16'h4321, 4'hF, 1'b0, 1'b0, 0, 2'd0, 4'h0, 0};  // priming edge
    tbl[1]  = '{16'h4321, 4'hF, 1'b0, 1'b0, 0, 2'd0, 4'h0, 0};
    tbl[2]  = '{16'h4521, 4'hF, 1'b0, 1'b0, 0, 2'd0, 4'h0, 0};  // ch2 -> 5, pending
    tbl[3]  = '{16'h4521, 4'hF, 1'b0, 1'b1, 1, 2'd2, 4'h5, 0};  // pushed
    tbl[4]  = '{16'h4521, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // popped
    tbl[5]  = '{16'h4531, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // ch1 -> 3
    tbl[6]  = '{16'h4531, 4'hF, 1'b1, 1'b1, 1, 2'd1, 4'h3, 0};  // rr_ptr becomes 1
    tbl[7]  = '{16'h5642, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // all four change
    tbl[8]  = '{16'h5642, 4'hF, 1'b1, 1'b1, 1, 2'd2, 4'h6, 0};
    tbl[9]  = '{16'h5642, 4'hF, 1'b1, 1'b1, 1, 2'd3, 4'h5, 0};
    tbl[10] = '{16'h5642, 4'hF, 1'b1, 1'b1, 1, 2'd0, 4'h2, 0};
    tbl[11] = '{16'h5642, 4'hF, 1'b1, 1'b1, 1, 2'd1, 4'h4, 0};
    tbl[12] = '{16'h5642, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};
    tbl[13] = '{16'h5643, 4'hE, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // ch0 changes while masked
    tbl[14] = '{16'h5643, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // unmask: no stale event
    tbl[15] = '{16'h5643, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};
    tbl[16] = '{16'h6643, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // ch3 pending
    tbl[17] = '{16'h6643, 4'h7, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};  // mask ch3 out: cleared
    tbl[18] = '{16'h6643, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};
    tbl[19] = '{16'h6643, 4'hF, 1'b1, 1'b0, 0, 2'd0, 4'h0, 0};

    rst_n     = 1'b0;
    ch_data   = 16'h4321;
    ch_mask   = 4'hF;
    evt_ready = 1'b0;
    #3;
    check("rst_vld",  evt_valid, 1'b0);
    check("rst_cnt",  fifo_count, 0);
    check("rst_head", {evt_ch, evt_data}, 6'h00);
    check("rst_coal", coalesce_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;

    sb.push_back({2'd2, 4'h5});
    sb.push_back({2'd1, 4'h3});
    sb.push_back({2'd2, 4'h6});
    sb.push_back({2'd3, 4'h5});
    sb.push_back({2'd0, 4'h2});
    sb.push_back({2'd1, 4'h4});

    for (int i = 0; i < 20; i++) begin
      ch_data   = tbl[i].dat;
      ch_mask   = tbl[i].msk;
      evt_ready = tbl[i].rdy;
      tick();
      check($sformatf("row%0d_vld", i), evt_valid, tbl[i].vld);
      check($sformatf("row%0d_cnt", i), fifo_count, tbl[i].cnt);
      check($sformatf("row%0d_coal", i), coalesce_cnt, tbl[i].coal);
      if (tbl[i].vld)
        check($sformatf("row%0d_head", i), {evt_ch, evt_data}, {tbl[i].ch, tbl[i].d});
    end

    // Fill the FIFO with two rounds of four events; rr_ptr is 1, so order is 2,3,0,1
    ch_mask = 4'hF;
    sb.push_back({2'd2, 4'h7}); sb.push_back({2'd3, 4'h7});
    sb.push_back({2'd0, 4'h4}); sb.push_back({2'd1, 4'h5});
    step(16'h7754, 1'b0);
    repeat (4) step(16'h7754, 1'b0);
    check("fill_half_cnt", fifo_count, 4);
    sb.push_back({2'd2, 4'h8}); sb.push_back({2'd3, 4'h8});
    sb.push_back({2'd0, 4'h5}); sb.push_back({2'd1, 4'h6});
    step(16'h8865, 1'b0);
    repeat (4) step(16'h8865, 1'b0);
    check_head("full", 8, 2'd2, 4'h7);

    // Coalescing on ch1 while full
    step(16'h8815, 1'b0);
    check("coal_first", coalesce_cnt, 0);
    step(16'h8825, 1'b0);
    check("coal_second", coalesce_cnt, 1);
    step(16'h8835, 1'b0);
    check("coal_third", coalesce_cnt, 2);
    check("coal_full_cnt", fifo_count, 8);

    // Push and pop at full: the merged ch1 event enters, count holds
    sb.push_back({2'd1, 4'h3});
    step(16'h8835, 1'b1);
    check_head("full_pushpop", 8, 2'd3, 4'h7);

    // Drain through pointer wrap-around
    repeat (7) step(16'h8835, 1'b1);
    check_head("drain_last", 1, 2'd1, 4'h3);
    step(16'h8835, 1'b1);
    check("drain_cnt", fifo_count, 0);
    check("drain_vld", evt_valid, 1'b0);
    check("drain_coal", coalesce_cnt, 2);

    // Push and pop at count 1
    sb.push_back({2'd0, 4'h6});
    sb.push_back({2'd3, 4'h9});
    step(16'h8836, 1'b1);
    check("c1_pre_cnt", fifo_count, 0);
    step(16'h9836, 1'b1);
    check_head("c1_first", 1, 2'd0, 4'h6);
    step(16'h9836, 1'b1);
    check_head("c1_pushpop", 1, 2'd3, 4'h9);
    step(16'h9836, 1'b1);
    check("c1_empty_cnt", fifo_count, 0);

    // Queue five events then reset asynchronously between edges
    step(16'hA947, 1'b0);
    step(16'hA947, 1'b0);
    step(16'hA947, 1'b0);
    step(16'hA948, 1'b0);
    step(16'hA948, 1'b0);
    step(16'hA948, 1'b0);
    check("pre_rst_cnt", fifo_count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld",  evt_valid, 1'b0);
    check("arst_cnt",  fifo_count, 0);
    check("arst_head", {evt_ch, evt_data}, 6'h00);
    check("arst_coal", coalesce_cnt, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(16'hA948, 1'b0);
      check($sformatf("reprime%0d_cnt", i), fifo_count, 0);
      check($sformatf("reprime%0d_vld", i), evt_valid, 1'b0);
    end

    // Detection works again after re-priming
    sb.push_back({2'd1, 4'h5});
    step(16'hA958, 1'b1);
    check("post_rst_chg_cnt", fifo_count, 0);
    step(16'hA958, 1'b1);
    check_head("post_rst_evt", 1, 2'd1, 4'h5);
    step(16'hA958, 1'b1);
    check("post_rst_drain", fifo_count, 0);

    check("sb_leftover", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
